// File: rtl/ecc_scrub_pkg.sv
// Shared types and defaults for the ECC scrub control stage.
// Holds the scheduler state encoding and the subsystem's default period/burst.
package ecc_scrub_pkg;

    typedef enum logic [1:0] {
        Off   = 2'd0,
        Wait  = 2'd1,
        Burst = 2'd2
    } scrub_ctrl_state_e;

    localparam int unsigned DefaultPeriod = 255;
    localparam int unsigned DefaultBurst  = 16;

endpackage

// File: rtl/ecc_sat_counter.sv
// Saturating event counter with a synchronous clear that overrides a same-cycle increment.
module ecc_sat_counter #(
    parameter int Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc,
    input  logic             clr,
    output logic [Width-1:0] count
);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != {Width{1'b1}})) begin
            count_q <= count_q + Width'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Duty-cycled scrub trigger generator plus error event counters and sticky interrupt
// for the cache ECC scrubber.
module ecc_scrub_ctrl
    import ecc_scrub_pkg::*;
#(
    parameter int PeriodWidth = 16,
    parameter int BurstWidth  = 8,
    parameter int CntWidth    = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   enable_i,
    input  logic [PeriodWidth-1:0] period_i,
    input  logic [BurstWidth-1:0]  burst_i,
    input  logic                   intc_busy_i,
    output logic                   scrub_trigger_o,
    input  logic                   bit_corrected_i,
    input  logic                   uncorrectable_i,
    input  logic                   clear_i,
    input  logic [CntWidth-1:0]    corr_threshold_i,
    output logic [CntWidth-1:0]    corr_count_o,
    output logic [CntWidth-1:0]    uncorr_count_o,
    output logic                   uncorr_seen_o,
    output logic                   irq_o
);

    scrub_ctrl_state_e      state_q;
    logic [PeriodWidth-1:0] timer_q;
    logic [BurstWidth-1:0]  burst_cnt_q;
    logic                   trigger_q;

    // trigger_q is kept in lockstep with state_q == Burst so the output is a plain flop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= Off;
            timer_q     <= '0;
            burst_cnt_q <= '0;
            trigger_q   <= 1'b0;
        end else if (!enable_i) begin
            state_q   <= Off;
            trigger_q <= 1'b0;
        end else begin
            case (state_q)
                Off: begin
                    state_q   <= Wait;
                    timer_q   <= period_i;
                    trigger_q <= 1'b0;
                end
                Wait: begin
                    if (timer_q != '0) begin
                        timer_q <= timer_q - PeriodWidth'(1);
                    end else if (burst_i != '0) begin
                        state_q     <= Burst;
                        burst_cnt_q <= burst_i;
                        trigger_q   <= 1'b1;
                    end else begin
                        timer_q <= period_i;
                    end
                end
                Burst: begin
                    // Busy cycles starve the scrubber, so they are not charged to the burst.
                    if (!intc_busy_i) begin
                        burst_cnt_q <= burst_cnt_q - BurstWidth'(1);
                        if (burst_cnt_q <= BurstWidth'(1)) begin
                            state_q   <= Wait;
                            timer_q   <= period_i;
                            trigger_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q   <= Off;
                    trigger_q <= 1'b0;
                end
            endcase
        end
    end

    assign scrub_trigger_o = trigger_q;

    ecc_sat_counter #(
        .Width (CntWidth)
    ) u_corr_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc    (bit_corrected_i),
        .clr    (clear_i),
        .count  (corr_count_o)
    );

    ecc_sat_counter #(
        .Width (CntWidth)
    ) u_uncorr_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc    (uncorrectable_i),
        .clr    (clear_i),
        .count  (uncorr_count_o)
    );

    // Threshold compares against the count as it will be after this cycle's pulse.
    logic [CntWidth-1:0] corr_count_d;
    logic                thr_hit;

    always_comb begin
        corr_count_d = corr_count_o;
        if (bit_corrected_i && (corr_count_o != {CntWidth{1'b1}})) begin
            corr_count_d = corr_count_o + CntWidth'(1);
        end
        thr_hit = (corr_threshold_i != '0) && (corr_count_d >= corr_threshold_i);
    end

    logic uncorr_seen_q;
    logic irq_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            uncorr_seen_q <= 1'b0;
            irq_q         <= 1'b0;
        end else if (clear_i) begin
            uncorr_seen_q <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            if (uncorrectable_i) begin
                uncorr_seen_q <= 1'b1;
            end
            if (thr_hit || uncorrectable_i) begin
                irq_q <= 1'b1;
            end
        end
    end

    assign uncorr_seen_o = uncorr_seen_q;
    assign irq_o         = irq_q;

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Randomized and directed bench for ecc_scrub_ctrl against a cycle-count reference model.
module tb_ecc_scrub_ctrl;

    localparam int PW  = 16;
    localparam int BW  = 8;
    localparam int CW  = 4;
    localparam int SAT = 15;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          en = 1'b0;
    logic [PW-1:0] per = '0;
    logic [BW-1:0] bur = '0;
    logic          busy = 1'b0;
    logic          trig;
    logic          bc = 1'b0;
    logic          unc = 1'b0;
    logic          clr = 1'b0;
    logic [CW-1:0] thr = '0;
    logic [CW-1:0] corr_cnt;
    logic [CW-1:0] unc_cnt;
    logic          seen;
    logic          irq;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mode 0=off, 1=waiting, 2=bursting; counts of remaining cycles.
    int m_mode, m_wait_left, m_burst_left;
    int m_corr, m_unc, m_seen, m_irq;

    always #5 clk = ~clk;

    ecc_scrub_ctrl #(
        .PeriodWidth (PW),
        .BurstWidth  (BW),
        .CntWidth    (CW)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .enable_i         (en),
        .period_i         (per),
        .burst_i          (bur),
        .intc_busy_i      (busy),
        .scrub_trigger_o  (trig),
        .bit_corrected_i  (bc),
        .uncorrectable_i  (unc),
        .clear_i          (clr),
        .corr_threshold_i (thr),
        .corr_count_o     (corr_cnt),
        .uncorr_count_o   (unc_cnt),
        .uncorr_seen_o    (seen),
        .irq_o            (irq)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_mode = 0; m_wait_left = 0; m_burst_left = 0;
        m_corr = 0; m_unc = 0; m_seen = 0; m_irq = 0;
    endfunction

    function automatic void model_update();
        if (clr) begin
            m_corr = 0; m_unc = 0; m_seen = 0; m_irq = 0;
        end else begin
            if (bc && m_corr < SAT) m_corr++;
            if (unc && m_unc < SAT) m_unc++;
            if (unc) m_seen = 1;
            if ((thr != 0 && m_corr >= int'(thr)) || unc) m_irq = 1;
        end
        if (!en) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            m_mode = 1; m_wait_left = int'(per) + 1;
        end else if (m_mode == 1) begin
            m_wait_left--;
            if (m_wait_left == 0) begin
                if (bur != 0) begin
                    m_mode = 2; m_burst_left = int'(bur);
                end else begin
                    m_wait_left = int'(per) + 1;
                end
            end
        end else if (!busy) begin
            m_burst_left--;
            if (m_burst_left == 0) begin
                m_mode = 1; m_wait_left = int'(per) + 1;
            end
        end
    endfunction

    task automatic check_all();
        check_val("trigger", int'(trig), (m_mode == 2) ? 1 : 0);
        check_val("corr_count", int'(corr_cnt), m_corr);
        check_val("uncorr_count", int'(unc_cnt), m_unc);
        check_val("uncorr_seen", int'(seen), m_seen);
        check_val("irq", int'(irq), m_irq);
    endtask

    // Inputs are set at a negedge; the next posedge samples them.
    task automatic step();
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic quiet();
        bc = 1'b0; unc = 1'b0; clr = 1'b0; busy = 1'b0;
    endtask

    task automatic go_off();
        en = 1'b0; quiet(); step();
    endtask

    task automatic reach_burst();
        int k;
        k = 0;
        while (m_mode != 2 && k < 200) begin
            step(); k++;
        end
        check_val("reach_burst", (m_mode == 2) ? 1 : 0, 1);
    endtask

    initial begin
        logic [11:0] hist12;
        logic [3:0]  hist4;
        int hi, cnt;

        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        check_val("reset_trigger", int'(trig), 0);
        check_val("reset_irq", int'(irq), 0);
        rst_ni = 1'b1;
        @(negedge clk);
        check_all();

        // Scheduling: period 3, burst 2.
        en = 1'b1; per = 16'd3; bur = 8'd2;
        hist12 = '0;
        for (int i = 0; i < 12; i++) begin
            step();
            hist12 = {hist12[10:0], trig};
        end
        check_val("sched_pattern", int'(hist12), int'(12'b0000_1100_0011));

        // Starvation: burst 4 with three busy cycles.
        go_off();
        en = 1'b1; per = 16'd1; bur = 8'd4;
        reach_burst();
        hi = 1;
        cnt = 0;
        while (trig && cnt < 20) begin
            busy = (cnt < 3);
            step();
            if (trig) hi++;
            cnt++;
        end
        busy = 1'b0;
        check_val("starve_len", hi, 7);

        // Disable mid-burst, then re-enable.
        per = 16'd3; bur = 8'd2;
        reach_burst();
        en = 1'b0; step();
        check_val("disable_drop", int'(trig), 0);
        en = 1'b1;
        cnt = 0;
        do begin
            step(); cnt++;
        end while (!trig && cnt < 50);
        check_val("reenable_delay", cnt, 5);

        // Threshold interrupt.
        go_off();
        thr = 4'd3;
        bc = 1'b1; step(); step();
        check_val("thr_irq_early", int'(irq), 0);
        step();
        check_val("thr_count", int'(corr_cnt), 3);
        check_val("thr_irq", int'(irq), 1);
        bc = 1'b0; clr = 1'b1; step();
        check_val("clr_count", int'(corr_cnt), 0);
        check_val("clr_irq", int'(irq), 0);
        bc = 1'b1; step();
        check_val("clr_beats_pulse", int'(corr_cnt), 0);
        quiet();

        // Uncorrectable and saturation.
        thr = 4'd0;
        unc = 1'b1; step(); unc = 1'b0;
        check_val("unc_seen", int'(seen), 1);
        check_val("unc_irq", int'(irq), 1);
        bc = 1'b1;
        repeat (20) step();
        bc = 1'b0; step();
        check_val("sat_count", int'(corr_cnt), 15);
        clr = 1'b1; step(); clr = 1'b0;

        // Zero burst never triggers.
        en = 1'b1; per = 16'd2; bur = 8'd0;
        hi = 0;
        repeat (30) begin
            step();
            if (trig) hi++;
        end
        check_val("zero_burst", hi, 0);

        // Zero period, burst 1.
        go_off();
        en = 1'b1; per = 16'd0; bur = 8'd1;
        hist4 = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            hist4 = {hist4[2:0], trig};
        end
        check_val("zero_period", int'(hist4), int'(4'b0101));

        // Asynchronous reset mid-burst.
        per = 16'd2; bur = 8'd5;
        bc = 1'b1; step(); bc = 1'b0;
        reach_burst();
        #2 rst_ni = 1'b0;
        #1 check_val("async_rst_trig", int'(trig), 0);
        check_val("async_rst_cnt", int'(corr_cnt), 0);
        model_reset();
        en = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        check_all();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            en   = ($urandom_range(0, 99) < 95);
            per  = PW'($urandom_range(0, 5));
            bur  = BW'($urandom_range(0, 4));
            busy = ($urandom_range(0, 99) < 30);
            bc   = ($urandom_range(0, 99) < 10);
            unc  = ($urandom_range(0, 99) < 2);
            clr  = ($urandom_range(0, 99) < 3);
            thr  = CW'($urandom_range(0, 6));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
